// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and
// a helper that gives the number of serial bit slots per character.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Unsupported parity modes count as no parity; any stop count other than 2 counts as 1.
  function automatic int bits_per_char(int byte_size, int parity_mode, int stop_bits);
    int par;
    int stp;
    par = (parity_mode == PAR_EVEN || parity_mode == PAR_ODD) ? 1 : 0;
    stp = (stop_bits == 2) ? 2 : 1;
    return 1 + byte_size + par + stp;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: free-running modulo CLKS_PER_BIT, tick on the last count.
// clear restarts the period so bit edges line up with the clearing event.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_tx_frame.sv
// Multi-byte UART transmitter: sends up to MAX_BYTES characters from one wide
// word, byte 0 first, with optional parity and one or two stop bits.
// Handshake: a request is taken on a rising edge where in_valid && in_ready;
// in_ready is high only while idle, and in_valid is ignored at all other times.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int BYTE_SIZE    = 8,
  parameter int MAX_BYTES    = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic [MAX_BYTES*BYTE_SIZE-1:0]    in_data,
  input  logic [$clog2(MAX_BYTES+1)-1:0]    in_len,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              out_bit,
  output logic                              out_busy,
  output logic                              out_done
);

  localparam int DW  = MAX_BYTES * BYTE_SIZE;
  localparam int LW  = $clog2(MAX_BYTES + 1);
  localparam int BIW = $clog2(BYTE_SIZE);
  localparam logic [LW-1:0]  MAX_LEN  = LW'(MAX_BYTES);
  localparam logic [BIW-1:0] LAST_BIT = BIW'(BYTE_SIZE - 1);
  localparam bit HAS_PAR  = (PARITY_MODE == PAR_EVEN) || (PARITY_MODE == PAR_ODD);
  localparam bit ODD_PAR  = (PARITY_MODE == PAR_ODD);
  localparam bit TWO_STOP = (STOP_BITS == 2);

  tx_state_t       state;
  logic [DW-1:0]   data_q;
  logic [LW-1:0]   bytes_left;
  logic [BIW-1:0]  bit_idx;
  logic            stop_idx;

  logic                 accept;
  logic                 tick;
  logic [LW-1:0]        len_c;
  logic [BYTE_SIZE-1:0] cur_char;
  logic [BIW-1:0]       bit_nxt;
  logic                 par_bit;

  assign accept   = in_valid && in_ready;
  assign len_c    = (in_len > MAX_LEN) ? MAX_LEN : in_len;
  assign cur_char = data_q[BYTE_SIZE-1:0];
  assign bit_nxt  = bit_idx + 1'b1;
  assign par_bit  = (^cur_char) ^ ODD_PAR;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clear (accept),
    .tick  (tick)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      data_q     <= '0;
      bytes_left <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      out_bit    <= 1'b1;
      in_ready   <= 1'b1;
      out_busy   <= 1'b0;
      out_done   <= 1'b0;
    end else begin
      out_done <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            in_ready <= 1'b0;
            if (len_c == '0) begin
              // Empty frame: nothing on the line, just a one-cycle handshake bubble.
              out_done <= 1'b1;
            end else begin
              state      <= START;
              data_q     <= in_data;
              bytes_left <= len_c;
              out_bit    <= 1'b0;
              out_busy   <= 1'b1;
            end
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            bit_idx <= '0;
            out_bit <= cur_char[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              if (HAS_PAR) begin
                state   <= PARITY;
                out_bit <= par_bit;
              end else begin
                state    <= STOP;
                stop_idx <= 1'b0;
                out_bit  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_nxt;
              out_bit <= cur_char[bit_nxt];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state    <= STOP;
            stop_idx <= 1'b0;
            out_bit  <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            if (TWO_STOP && !stop_idx) begin
              stop_idx <= 1'b1;
            end else if (bytes_left == LW'(1)) begin
              state      <= IDLE;
              bytes_left <= '0;
              out_busy   <= 1'b0;
              out_done   <= 1'b1;
              in_ready   <= 1'b1;
            end else begin
              // Next character starts immediately: no idle gap between bytes.
              state      <= START;
              bytes_left <= bytes_left - 1'b1;
              data_q     <= data_q >> BYTE_SIZE;
              out_bit    <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three parity/stop configurations share one clock;
// the expected serial waveform per cycle is queued up front and popped as the line is sampled.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int CPB = 4;
  localparam int DW  = 32;
  localparam int LW  = 3;

  logic          CLK;
  logic          RST_N;
  logic [DW-1:0] in_data;
  logic [LW-1:0] in_len;
  logic [2:0]    in_valid;
  logic [2:0]    in_ready;
  logic [2:0]    out_bit;
  logic [2:0]    out_busy;
  logic [2:0]    out_done;

  logic [0:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  uart_tx_frame #(.PARITY_MODE(PAR_NONE), .STOP_BITS(1)) u_none (
    .CLK(CLK), .RST_N(RST_N), .in_data(in_data), .in_len(in_len),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .out_bit(out_bit[0]),
    .out_busy(out_busy[0]), .out_done(out_done[0])
  );

  uart_tx_frame #(.PARITY_MODE(PAR_EVEN), .STOP_BITS(1)) u_even (
    .CLK(CLK), .RST_N(RST_N), .in_data(in_data), .in_len(in_len),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .out_bit(out_bit[1]),
    .out_busy(out_busy[1]), .out_done(out_done[1])
  );

  uart_tx_frame #(.PARITY_MODE(PAR_ODD), .STOP_BITS(2)) u_odd2 (
    .CLK(CLK), .RST_N(RST_N), .in_data(in_data), .in_len(in_len),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .out_bit(out_bit[2]),
    .out_busy(out_busy[2]), .out_done(out_done[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_bit(input logic b);
    for (int i = 0; i < CPB; i++) exp_q.push_back(b);
  endtask

  // Reference waveform: start 0, data LSB first, optional parity, stop bit(s) 1.
  task automatic build_exp(input logic [DW-1:0] data, input int nbytes, input int pm, input int sb);
    logic [7:0] ch;
    logic       p;
    for (int b = 0; b < nbytes; b++) begin
      ch = data[b*8 +: 8];
      p  = 1'b0;
      push_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
        push_bit(ch[i]);
        p = p ^ ch[i];
      end
      if (pm == 1) push_bit(p);
      if (pm == 2) push_bit(~p);
      for (int s = 0; s < sb; s++) push_bit(1'b1);
    end
  endtask

  task automatic start_frame(input int sel, input logic [DW-1:0] data, input logic [LW-1:0] len,
                             input bit hold);
    @(negedge CLK);
    in_data       = data;
    in_len        = len;
    in_valid[sel] = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    if (!hold) begin
      in_valid[sel] = 1'b0;
      in_data       = $urandom();
      in_len        = LW'($urandom_range(0, 6));
    end
  endtask

  // Entered at the first cycle after accept; returns sampling the out_done cycle.
  task automatic check_frame(input int sel, input int exp_cycles, input int poke_at);
    int cyc;
    cyc = 1;
    while (out_done[sel] !== 1'b1) begin
      if (cyc > exp_cycles + 8) begin
        check("done_timeout", cyc, exp_cycles + 1);
        break;
      end
      if (exp_q.size() > 0) check("line_bit", out_bit[sel], exp_q.pop_front());
      else check("line_extra_bit", cyc, exp_cycles);
      check("busy_in_frame", out_busy[sel], 1'b1);
      check("ready_in_frame", in_ready[sel], 1'b0);
      if (poke_at != 0 && cyc == poke_at) begin
        in_valid[sel] = 1'b1;
        in_data       = 32'hDEAD_BEEF;
        in_len        = 3'd2;
      end
      if (poke_at != 0 && cyc == poke_at + 3) in_valid[sel] = 1'b0;
      @(negedge CLK);
      cyc++;
    end
    check("done_cycle", cyc, exp_cycles + 1);
    check("queue_drained", exp_q.size(), 0);
    check("ready_at_done", in_ready[sel], 1'b1);
    check("busy_at_done", out_busy[sel], 1'b0);
    check("line_at_done", out_bit[sel], 1'b1);
  endtask

  task automatic after_done(input int sel);
    @(negedge CLK);
    check("done_single", out_done[sel], 1'b0);
    check("line_idle", out_bit[sel], 1'b1);
    check("ready_idle", in_ready[sel], 1'b1);
  endtask

  initial begin
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    RST_N    = 1'b0;
    in_data  = '0;
    in_len   = '0;
    in_valid = '0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    for (int s = 0; s < 3; s++) begin
      check("rst_bit", out_bit[s], 1'b1);
      check("rst_ready", in_ready[s], 1'b1);
      check("rst_busy", out_busy[s], 1'b0);
      check("rst_done", out_done[s], 1'b0);
    end

    // Single byte, no parity: 40 cycles, done on cycle 41.
    build_exp(32'h0000_0047, 1, 0, 1);
    start_frame(0, 32'h0000_0047, 3'd1, 1'b0);
    check_frame(0, 40, 0);
    after_done(0);

    // Three bytes back-to-back with a mid-frame request that must be ignored.
    build_exp(32'h00AA_BB47, 3, 0, 1);
    start_frame(0, 32'h00AA_BB47, 3'd3, 1'b0);
    check_frame(0, 120, 50);
    after_done(0);

    // Even parity, then odd parity with two stop bits.
    build_exp(32'h0000_0047, 1, 1, 1);
    start_frame(1, 32'h0000_0047, 3'd1, 1'b0);
    check_frame(1, 44, 0);
    after_done(1);

    build_exp(32'h0000_0047, 1, 2, 2);
    start_frame(2, 32'h0000_0047, 3'd1, 1'b0);
    check_frame(2, 48, 0);
    after_done(2);

    // Zero-length request: only the handshake bubble.
    start_frame(0, 32'h1234_5678, 3'd0, 1'b0);
    check("len0_done", out_done[0], 1'b1);
    check("len0_ready", in_ready[0], 1'b0);
    check("len0_bit", out_bit[0], 1'b1);
    check("len0_busy", out_busy[0], 1'b0);
    after_done(0);

    // Oversized length is clamped to four bytes.
    build_exp(32'h1122_3344, 4, 0, 1);
    start_frame(0, 32'h1122_3344, 3'd6, 1'b0);
    check_frame(0, 160, 0);
    after_done(0);

    // in_valid held high: second start bit follows the done cycle directly.
    d1 = $urandom();
    d2 = $urandom();
    build_exp(d1, 2, 0, 1);
    start_frame(0, d1, 3'd2, 1'b1);
    check_frame(0, 80, 0);
    in_data = d2;
    build_exp(d2, 2, 0, 1);
    @(negedge CLK);
    in_valid[0] = 1'b0;
    check_frame(0, 80, 0);
    after_done(0);

    // Asynchronous reset mid-frame, then a clean frame.
    start_frame(0, 32'h0000_0000, 3'd1, 1'b0);
    repeat (14) @(negedge CLK);
    check("pre_reset_busy", out_busy[0], 1'b1);
    #1 RST_N = 1'b0;
    #1;
    check("async_rst_bit", out_bit[0], 1'b1);
    check("async_rst_ready", in_ready[0], 1'b1);
    check("async_rst_busy", out_busy[0], 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    build_exp(32'h0000_00A5, 1, 0, 1);
    start_frame(0, 32'h0000_00A5, 3'd1, 1'b0);
    check_frame(0, 40, 0);
    after_done(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
